// File: rtl/copad_trig_ctrl.sv
// ----------------------------------------------------------------------------
// copad_trig_ctrl
//
// Purpose:
//   Turns the GEM co-pad finder's registered match outputs into self-trigger
//   requests for the TMB trigger logic. A qualifying match (any-match with at
//   least one unmasked active FEB) is prescaled. It then raises trig_req with
//   a latched FEB list and match vector. The request is held until trig_ack
//   or until an ack timeout, and is then followed by a programmable deadtime.
//   The controller also owns the finder's neighbour-match setting. That
//   setting only follows its configuration input while idle, so it never
//   changes under an armed or in-flight trigger.
//
// Optional feature:
//   COPAD_TRIG_LOST_CNT_EN - when defined, n_lost counts qualifying matches
//   seen while busy (FIRE/DEAD). When undefined, n_lost is tied to zero.
//
// Ports:
//   clock, reset            40 MHz fabric clock, asynchronous active-high reset
//   cfg_enable              arm the controller
//   cfg_match_neighbors     requested neighbour-match setting
//   cfg_feb_mask            1 = FEB may trigger
//   cfg_prescale            fire on every (N+1)th qualifying match
//   cfg_deadtime            bx of holdoff after ack or timeout
//   copad_match_neighbors   neighbour-match setting driven to the finder
//   copad_any_match         finder any-match flag
//   copad_match             finder per-cluster match flags
//   copad_active_feb_list   finder active-FEB list
//   trig_req / trig_ack     self-trigger request / downstream acknowledge
//   trig_feb_list           latched masked FEB list for the request
//   trig_match              latched match vector for the request
//   busy                    state is FIRE or DEAD
//   ack_timeout_err         sticky: a request timed out
//   n_fired, n_lost         saturating statistics counters
// ----------------------------------------------------------------------------
module copad_trig_ctrl #(
    parameter int MXFEB             = 24,
    parameter int MXCLUSTER_CHAMBER = 8,
    parameter int PRESCB            = 8,
    parameter int DEADB             = 8,
    parameter int TOB               = 6,
    parameter int CNTB              = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cfg_enable,
    input  logic                         cfg_match_neighbors,
    input  logic [MXFEB-1:0]             cfg_feb_mask,
    input  logic [PRESCB-1:0]            cfg_prescale,
    input  logic [DEADB-1:0]             cfg_deadtime,
    output logic                         copad_match_neighbors,
    input  logic                         copad_any_match,
    input  logic [MXCLUSTER_CHAMBER-1:0] copad_match,
    input  logic [MXFEB-1:0]             copad_active_feb_list,
    output logic                         trig_req,
    input  logic                         trig_ack,
    output logic [MXFEB-1:0]             trig_feb_list,
    output logic [MXCLUSTER_CHAMBER-1:0] trig_match,
    output logic                         busy,
    output logic                         ack_timeout_err,
    output logic [CNTB-1:0]              n_fired,
    output logic [CNTB-1:0]              n_lost
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FIRE  = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    // The timeout fires during the FIRE cycle in which the counter would step
    // to all-ones. The request is therefore held for 2^TOB-1 cycles without ack.
    localparam logic [TOB-1:0] TO_LAST = {{(TOB-1){1'b1}}, 1'b0};

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PRESCB-1:0]      r_presc_cnt;
    logic [PRESCB-1:0]      w_presc_cnt_next;
    logic [DEADB-1:0]       r_dead_cnt;
    logic [DEADB-1:0]       w_dead_cnt_next;
    logic [TOB-1:0]         r_to_cnt;
    logic [TOB-1:0]         w_to_cnt_next;
    logic [MXFEB-1:0]       r_trig_feb_list;
    logic [MXCLUSTER_CHAMBER-1:0] r_trig_match;
    logic                   r_match_neighbors;
    logic                   r_ack_timeout_err;
    logic [CNTB-1:0]        r_n_fired;

    logic [MXFEB-1:0]       w_masked_feb;
    logic                   w_qual;
    logic                   w_latch;
    logic                   w_fired_inc;
    logic                   w_timeout_set;
    logic                   w_busy;

    assign w_masked_feb = copad_active_feb_list & cfg_feb_mask;
    assign w_qual       = copad_any_match & (|w_masked_feb);
    assign w_busy       = (r_state == S_FIRE) || (r_state == S_DEAD);

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_presc_cnt_next = r_presc_cnt;
        w_dead_cnt_next  = r_dead_cnt;
        w_to_cnt_next    = r_to_cnt;
        w_latch          = 1'b0;
        w_fired_inc      = 1'b0;
        w_timeout_set    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cfg_enable) begin
                    w_state_next     = S_ARMED;
                    w_presc_cnt_next = '0;
                end
            end

            S_ARMED: begin
                if (!cfg_enable) begin
                    w_state_next = S_IDLE;
                end else if (w_qual) begin
                    if (r_presc_cnt == cfg_prescale) begin
                        w_latch          = 1'b1;
                        w_presc_cnt_next = '0;
                        w_to_cnt_next    = '0;
                        w_state_next     = S_FIRE;
                    end else begin
                        w_presc_cnt_next = r_presc_cnt + 1'b1;
                    end
                end
            end

            S_FIRE: begin
                // Abort has priority, so an ack in the same cycle is dropped.
                if (!cfg_enable) begin
                    w_state_next = S_IDLE;
                end else if (trig_ack) begin
                    w_fired_inc     = 1'b1;
                    w_dead_cnt_next = cfg_deadtime;
                    w_state_next    = (cfg_deadtime == '0) ? S_ARMED : S_DEAD;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout_set   = 1'b1;
                    w_to_cnt_next   = r_to_cnt + 1'b1;
                    w_dead_cnt_next = cfg_deadtime;
                    w_state_next    = (cfg_deadtime == '0) ? S_ARMED : S_DEAD;
                end else begin
                    w_to_cnt_next = r_to_cnt + 1'b1;
                end
            end

            S_DEAD: begin
                if (!cfg_enable) begin
                    w_state_next = S_IDLE;
                end else if (r_dead_cnt <= 1) begin
                    // Leaves after exactly cfg_deadtime cycles; the <= also
                    // guards against ever sitting in DEAD with a zero count.
                    w_dead_cnt_next = '0;
                    w_state_next    = S_ARMED;
                end else begin
                    w_dead_cnt_next = r_dead_cnt - 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_presc_cnt       <= '0;
            r_dead_cnt        <= '0;
            r_to_cnt          <= '0;
            r_trig_feb_list   <= '0;
            r_trig_match      <= '0;
            r_match_neighbors <= 1'b0;
            r_ack_timeout_err <= 1'b0;
            r_n_fired         <= '0;
        end else begin
            r_state     <= w_state_next;
            r_presc_cnt <= w_presc_cnt_next;
            r_dead_cnt  <= w_dead_cnt_next;
            r_to_cnt    <= w_to_cnt_next;

            if (w_latch) begin
                r_trig_feb_list <= w_masked_feb;
                r_trig_match    <= copad_match;
            end

            // Finder configuration only moves while nothing is in flight.
            if (r_state == S_IDLE) begin
                r_match_neighbors <= cfg_match_neighbors;
            end

            if (w_timeout_set) begin
                r_ack_timeout_err <= 1'b1;
            end

            if (w_fired_inc && (r_n_fired != {CNTB{1'b1}})) begin
                r_n_fired <= r_n_fired + 1'b1;
            end
        end
    end

`ifdef COPAD_TRIG_LOST_CNT_EN
    logic [CNTB-1:0] r_n_lost;

    // The ARMED cycle that launches a trigger is not busy, so it is never
    // counted as lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_n_lost <= '0;
        end else if (w_qual && w_busy && (r_n_lost != {CNTB{1'b1}})) begin
            r_n_lost <= r_n_lost + 1'b1;
        end
    end

    assign n_lost = r_n_lost;
`else
    assign n_lost = '0;
`endif

    // trig_req is decoded straight from the state register, so it is low
    // as soon as reset is asserted.
    assign trig_req              = (r_state == S_FIRE);
    assign busy                  = w_busy;
    assign trig_feb_list         = r_trig_feb_list;
    assign trig_match            = r_trig_match;
    assign copad_match_neighbors = r_match_neighbors;
    assign ack_timeout_err       = r_ack_timeout_err;
    assign n_fired               = r_n_fired;

endmodule

// File: tb/tb_copad_trig_ctrl.sv
// ----------------------------------------------------------------------------
// tb_copad_trig_ctrl
//
// Directed bench for copad_trig_ctrl. A table of single-cycle vectors covers
// the basic fire/ack/deadtime flow and FEB masking with prescale. Hand-written
// sequences then cover prescale counting, ack timeout, lost-match counting,
// neighbour-setting hold, abort, and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_copad_trig_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_enable;
    logic        cfg_match_neighbors;
    logic [23:0] cfg_feb_mask;
    logic [7:0]  cfg_prescale;
    logic [7:0]  cfg_deadtime;
    logic        copad_match_neighbors;
    logic        copad_any_match;
    logic [7:0]  copad_match;
    logic [23:0] copad_active_feb_list;
    logic        trig_req;
    logic        trig_ack;
    logic [23:0] trig_feb_list;
    logic [7:0]  trig_match;
    logic        busy;
    logic        ack_timeout_err;
    logic [15:0] n_fired;
    logic [15:0] n_lost;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    copad_trig_ctrl dut (
        .clock                 (clock),
        .reset                 (reset),
        .cfg_enable            (cfg_enable),
        .cfg_match_neighbors   (cfg_match_neighbors),
        .cfg_feb_mask          (cfg_feb_mask),
        .cfg_prescale          (cfg_prescale),
        .cfg_deadtime          (cfg_deadtime),
        .copad_match_neighbors (copad_match_neighbors),
        .copad_any_match       (copad_any_match),
        .copad_match           (copad_match),
        .copad_active_feb_list (copad_active_feb_list),
        .trig_req              (trig_req),
        .trig_ack              (trig_ack),
        .trig_feb_list         (trig_feb_list),
        .trig_match            (trig_match),
        .busy                  (busy),
        .ack_timeout_err       (ack_timeout_err),
        .n_fired               (n_fired),
        .n_lost                (n_lost)
    );

    typedef struct {
        logic        en;
        logic        am;
        logic [23:0] act;
        logic [7:0]  m;
        logic [23:0] mask;
        logic [7:0]  presc;
        logic [7:0]  dead;
        logic        ack;
        logic        e_req;
        logic        e_busy;
        logic [23:0] e_feb;
        logic [7:0]  e_match;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic en, input logic am, input logic [23:0] act,
                                input logic [7:0] m, input logic [23:0] mask,
                                input logic [7:0] presc, input logic [7:0] dead,
                                input logic ack, input logic e_req, input logic e_busy,
                                input logic [23:0] e_feb, input logic [7:0] e_match);
        vec_t v;
        v.en = en; v.am = am; v.act = act; v.m = m; v.mask = mask;
        v.presc = presc; v.dead = dead; v.ack = ack;
        v.e_req = e_req; v.e_busy = e_busy; v.e_feb = e_feb; v.e_match = e_match;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end else begin
            $display("ok   %s: %0h", name, actual);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int          exp_fired;
    int          exp_lost;
    logic [5:0]  fire_pattern;

    initial begin
        // Table: basic flow (mask all-ones, prescale 0, deadtime 4), then
        // masking with prescale 1 (masked matches must not advance the count).
        vecs[0]  = mk(1, 0, 24'h000000, 8'h00, 24'hFFFFFF, 0, 4, 0, 0, 0, 24'h000000, 8'h00);
        vecs[1]  = mk(1, 1, 24'h000100, 8'h81, 24'hFFFFFF, 0, 4, 0, 1, 1, 24'h000100, 8'h81);
        vecs[2]  = mk(1, 0, 24'h000000, 8'h00, 24'hFFFFFF, 0, 4, 0, 1, 1, 24'h000100, 8'h81);
        vecs[3]  = mk(1, 0, 24'h000000, 8'h00, 24'hFFFFFF, 0, 4, 1, 0, 1, 24'h000100, 8'h81);
        vecs[4]  = mk(1, 0, 24'h000000, 8'h00, 24'hFFFFFF, 0, 4, 0, 0, 1, 24'h000100, 8'h81);
        vecs[5]  = mk(1, 0, 24'h000000, 8'h00, 24'hFFFFFF, 0, 4, 0, 0, 1, 24'h000100, 8'h81);
        vecs[6]  = mk(1, 0, 24'h000000, 8'h00, 24'hFFFFFF, 0, 4, 0, 0, 1, 24'h000100, 8'h81);
        vecs[7]  = mk(1, 0, 24'h000000, 8'h00, 24'hFFFFFF, 0, 4, 0, 0, 0, 24'h000100, 8'h81);
        vecs[8]  = mk(1, 1, 24'h000100, 8'h11, 24'h0000FF, 1, 4, 0, 0, 0, 24'h000100, 8'h81);
        vecs[9]  = mk(1, 1, 24'h000100, 8'h11, 24'h0000FF, 1, 4, 0, 0, 0, 24'h000100, 8'h81);
        vecs[10] = mk(1, 1, 24'h000001, 8'h22, 24'h0000FF, 1, 4, 0, 0, 0, 24'h000100, 8'h81);
        vecs[11] = mk(1, 1, 24'h000301, 8'h3C, 24'h0000FF, 1, 4, 0, 1, 1, 24'h000001, 8'h3C);
        vecs[12] = mk(1, 0, 24'h000000, 8'h00, 24'h0000FF, 1, 4, 1, 0, 1, 24'h000001, 8'h3C);
        vecs[13] = mk(1, 0, 24'h000000, 8'h00, 24'h0000FF, 1, 4, 0, 0, 1, 24'h000001, 8'h3C);
        vecs[14] = mk(1, 0, 24'h000000, 8'h00, 24'h0000FF, 1, 4, 0, 0, 1, 24'h000001, 8'h3C);
        vecs[15] = mk(1, 0, 24'h000000, 8'h00, 24'h0000FF, 1, 4, 0, 0, 1, 24'h000001, 8'h3C);
        vecs[16] = mk(1, 0, 24'h000000, 8'h00, 24'h0000FF, 1, 4, 0, 0, 0, 24'h000001, 8'h3C);

        `ifdef COPAD_TRIG_LOST_CNT_EN
        exp_lost = 9;
        `else
        exp_lost = 0;
        `endif
        exp_fired = 0;

        // ---------------- reset ----------------
        reset = 1'b1;
        cfg_enable = 0; cfg_match_neighbors = 0; cfg_feb_mask = '0;
        cfg_prescale = 0; cfg_deadtime = 0; copad_any_match = 0;
        copad_match = 0; copad_active_feb_list = 0; trig_ack = 0;
        tick(); tick();
        chk("rst_req", 32'(trig_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_feb", 32'(trig_feb_list), 0);
        chk("rst_err", 32'(ack_timeout_err), 0);
        chk("rst_fired", 32'(n_fired), 0);
        chk("rst_lost", 32'(n_lost), 0);
        chk("rst_nb", 32'(copad_match_neighbors), 0);
        reset = 1'b0;
        tick();

        // ---------------- table ----------------
        for (int i = 0; i < NVEC; i++) begin
            cfg_enable = vecs[i].en;
            copad_any_match = vecs[i].am;
            copad_active_feb_list = vecs[i].act;
            copad_match = vecs[i].m;
            cfg_feb_mask = vecs[i].mask;
            cfg_prescale = vecs[i].presc;
            cfg_deadtime = vecs[i].dead;
            trig_ack = vecs[i].ack;
            tick();
            chk($sformatf("vec%0d_req", i), 32'(trig_req), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_feb", i), 32'(trig_feb_list), 32'(vecs[i].e_feb));
            chk($sformatf("vec%0d_match", i), 32'(trig_match), 32'(vecs[i].e_match));
        end
        exp_fired = 2;
        chk("table_fired", 32'(n_fired), 32'(exp_fired));
        chk("table_lost", 32'(n_lost), 0);

        // ---------------- prescale 2, immediate ack, deadtime 0 ----------------
        copad_any_match = 0; trig_ack = 1;
        cfg_feb_mask = 24'hFFFFFF; cfg_prescale = 2; cfg_deadtime = 0;
        fire_pattern = '0;
        for (int i = 0; i < 6; i++) begin
            copad_any_match = 1; copad_active_feb_list = 24'h000010;
            tick();
            fire_pattern[i] = trig_req;
            copad_any_match = 0;
            for (int j = 0; j < 9; j++) tick();
        end
        exp_fired += 2;
        chk("presc_pattern", 32'(fire_pattern), 32'b100100);
        chk("presc_fired", 32'(n_fired), 32'(exp_fired));

        // ---------------- ack timeout ----------------
        trig_ack = 0; cfg_deadtime = 3; cfg_prescale = 0;
        copad_any_match = 1;
        tick();
        chk("to_req_start", 32'(trig_req), 1);
        copad_any_match = 0;
        repeat (60) tick();
        chk("to_req_held", 32'(trig_req), 1);
        chk("to_err_early", 32'(ack_timeout_err), 0);
        repeat (4) tick();
        chk("to_req_drop", 32'(trig_req), 0);
        chk("to_busy_dead", 32'(busy), 1);
        chk("to_err_set", 32'(ack_timeout_err), 1);
        trig_ack = 1;
        repeat (10) tick();
        chk("to_fired_same", 32'(n_fired), 32'(exp_fired));
        chk("to_busy_rearm", 32'(busy), 0);
        chk("to_err_sticky", 32'(ack_timeout_err), 1);

        // ---------------- lost matches, deadtime 8 ----------------
        cfg_deadtime = 8; copad_any_match = 1; copad_active_feb_list = 24'h000400;
        repeat (10) tick();
        copad_any_match = 0;
        exp_fired += 1;
        chk("lost_count", 32'(n_lost), 32'(exp_lost));
        chk("lost_rearmed", 32'(busy), 0);
        chk("lost_fired", 32'(n_fired), 32'(exp_fired));

        // ---------------- neighbour hold, abort ----------------
        copad_any_match = 1;
        tick();
        copad_any_match = 0;
        tick();
        exp_fired += 1;
        cfg_match_neighbors = 1;
        repeat (3) tick();
        chk("nb_hold_dead", 32'(copad_match_neighbors), 0);
        chk("nb_in_dead", 32'(busy), 1);
        cfg_enable = 0;
        tick();
        chk("nb_idle_busy", 32'(busy), 0);
        tick();
        chk("nb_follow", 32'(copad_match_neighbors), 1);
        chk("nb_fired", 32'(n_fired), 32'(exp_fired));

        trig_ack = 0; cfg_enable = 1;
        tick();
        copad_any_match = 1;
        tick();
        chk("abort_req_up", 32'(trig_req), 1);
        copad_any_match = 0; cfg_enable = 0; trig_ack = 1;
        tick();
        chk("abort_req", 32'(trig_req), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_fired", 32'(n_fired), 32'(exp_fired));
        trig_ack = 0; cfg_match_neighbors = 0;
        tick(); tick();
        chk("nb_follow0", 32'(copad_match_neighbors), 0);

        // ---------------- asynchronous reset mid-request ----------------
        cfg_enable = 1;
        tick();
        copad_any_match = 1;
        tick();
        copad_any_match = 0;
        chk("arst_req_up", 32'(trig_req), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_req", 32'(trig_req), 0);
        chk("arst_fired", 32'(n_fired), 0);
        chk("arst_err", 32'(ack_timeout_err), 0);
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/copad_trig_ctrl.md
Name: copad_trig_ctrl

Overview:
- Sequences the GEM co-pad finder's registered outputs into GEM self-trigger requests toward the TMB trigger logic.
- Applies an FEB mask, a prescale, a request/acknowledge handshake with timeout, and programmable deadtime.
- Owns the finder's neighbour-match configuration and keeps it stable while a trigger is in flight.
- Sits directly after the co-pad finder on the 40 MHz fabric clock.

Parameters:
MXFEB, 24, number of GEM FEBs (width of FEB lists)
MXCLUSTER_CHAMBER, 8, clusters per chamber (width of match vector)
PRESCB, 8, prescale register width
DEADB, 8, deadtime register width
TOB, 6, ack-timeout counter width
CNTB, 16, statistics counter width

Ports:
clock  in  1  40 MHz fabric clock
reset  in  1  asynchronous, active-high reset
cfg_enable  in  1  arm the controller
cfg_match_neighbors  in  1  requested neighbour-match setting
cfg_feb_mask  in  MXFEB  1 = FEB may trigger
cfg_prescale  in  PRESCB  fire on every (N+1)th qualifying match
cfg_deadtime  in  DEADB  bx of holdoff after ack or timeout
copad_match_neighbors  out  1  neighbour-match setting driven to the co-pad finder
copad_any_match  in  1  finder any-match flag
copad_match  in  MXCLUSTER_CHAMBER  finder per-cluster match flags
copad_active_feb_list  in  MXFEB  finder active-FEB list
trig_req  out  1  self-trigger request
trig_ack  in  1  downstream acknowledge
trig_feb_list  out  MXFEB  latched masked FEB list for the request
trig_match  out  MXCLUSTER_CHAMBER  latched match vector for the request
busy  out  1  state is FIRE or DEAD
ack_timeout_err  out  1  sticky: a request timed out
n_fired  out  CNTB  acknowledged triggers, saturating
n_lost  out  CNTB  qualifying matches dropped, saturating

Behaviour:
- Reset (async): state IDLE; all outputs 0; prescale, dead and timeout counters 0.
- Qualify: qual = copad_any_match & |(copad_active_feb_list & cfg_feb_mask).
- IDLE:
  - copad_match_neighbors <= cfg_match_neighbors every cycle; this is the only state where it updates.
  - cfg_enable=1 -> ARMED; prescale counter cleared.
- ARMED:
  - cfg_enable=0 -> IDLE.
  - On qual with presc_cnt==cfg_prescale:
    - latch trig_feb_list <= active list & mask;
    - latch trig_match <= copad_match;
    - presc_cnt <= 0; next state FIRE.
    - trig_req asserts the cycle after qual (latency 1).
  - On qual otherwise: presc_cnt++.
  - cfg_prescale=0: every qual fires.
- FIRE:
  - trig_req=1; trig_feb_list and trig_match are held stable.
  - trig_ack=1 (sampled high):
    - trig_req drops next cycle;
    - n_fired++ (saturates at all-ones);
    - dead_cnt <= cfg_deadtime; next state DEAD, or ARMED if cfg_deadtime==0.
  - Timeout counter increments each FIRE cycle. On reaching 2^TOB-1 without ack:
    - set ack_timeout_err;
    - trig_req drops; enter DEAD (same deadtime rule); n_fired unchanged.
  - cfg_enable=0 in FIRE: abort, trig_req drops next cycle, -> IDLE; trig_ack that same cycle is ignored.
  - Timeout counter clears on entry to FIRE.
- DEAD:
  - dead_cnt decrements each cycle; at dead_cnt==1 -> ARMED (exactly cfg_deadtime cycles in DEAD).
  - cfg_enable=0 -> IDLE.
- Lost matches: any qual while in FIRE or DEAD increments n_lost (saturating). The FIRE entry cycle itself is not counted.
- trig_ack outside FIRE: ignored.
- ack_timeout_err: cleared only by reset.
- Statistics counters: held through enable cycling; cleared only by reset.
- cfg_* changes in ARMED/FIRE/DEAD take effect the next cycle they are sampled, except cfg_match_neighbors (IDLE only).
- Mid-operation reset: immediate return to reset values, trig_req low asynchronously.

Optional Feature:
- Macro: COPAD_TRIG_LOST_CNT_EN.
- Defined: n_lost counter implemented as above.
- Undefined: n_lost tied to 0; no counter logic synthesized; all other behaviour unchanged.

Test Plan:
- Reset, enable=1, mask=all-ones, prescale=0, deadtime=4; one-cycle any_match with active_feb_list=24'h000100 -> trig_req high next cycle, trig_feb_list=24'h000100; ack after 2 cycles -> trig_req low next cycle, busy for 4 cycles, n_fired=1.
- prescale=2, 6 qualifying matches spaced 10 bx, immediate ack, deadtime=0 -> exactly 2 requests (3rd and 6th match), n_fired=2.
- mask=24'h0000FF, active_feb_list=24'h000100 with any_match=1 -> no request, presc_cnt unchanged; change active list to 24'h000001 -> request.
- No ack for 63 cycles (TOB=6) -> ack_timeout_err=1, trig_req low, DEAD entered, n_fired=0; later ack ignored.
- Matches every cycle with deadtime=8 and ack in first FIRE cycle -> n_lost=9 before re-arm; with COPAD_TRIG_LOST_CNT_EN undefined, n_lost=0.
- Toggle cfg_match_neighbors during DEAD -> copad_match_neighbors unchanged until enable=0 (IDLE), then follows within 1 cycle; enable dropped during FIRE -> trig_req low next cycle, state IDLE.
